lsu_dccm_wrbuf: RTL
===================

Name: lsu_dccm_wrbuf

Overview:
Committed-store write buffer sitting directly upstream of the DCCM bank array; owns the array's write port (write enable, write address, write data).
- Queues word stores retired from DC4 in FIFO order.
- Drains one entry per cycle into the DCCM whenever the load pipe is not reading and the pipe is not frozen.
- Provides youngest-match store-to-load forwarding so loads see buffered data.

Parameters:
DEPTH, 4, number of entries; power of 2, at least 2
ADDR_W, `RV_DCCM_BITS, DCCM byte address width
DATA_W, 39, word data width including ECC (DCCM_FDATA_WIDTH)
STARVE_MAX, 8, consecutive full-and-blocked cycles before the buffer takes priority over loads

Ports:
clk  in  1  clock
rst_l  in  1  asynchronous active-low reset
lsu_freeze_dc3  in  1  pipeline freeze; no drain while high
stbuf_push  in  1  enqueue a committed store
stbuf_addr  in  ADDR_W  store byte address; word address is [ADDR_W-1:2]
stbuf_data  in  DATA_W  store data with ECC
stbuf_full  out  DEPTH-entry buffer full
stbuf_empty  out  1  buffer empty
stbuf_count  out  $clog2(DEPTH)+1  occupancy
ld_rden  in  1  load pipe requests the DCCM read port this cycle
ld_stall  out  1  load must hold; buffer is forcing a drain
fwd_addr  in  ADDR_W  load address for the forwarding lookup
fwd_hit  out  1  a valid entry matches the word address of fwd_addr
fwd_data  out  DATA_W  data of the youngest matching entry
dccm_wren  out  1  write enable to the DCCM
dccm_wr_addr  out  ADDR_W  write address to the DCCM
dccm_wr_data  out  DATA_W  write data to the DCCM

Behaviour:
- Storage:
  - Circular array; rd_ptr and wr_ptr are $clog2(DEPTH) bits and wrap naturally.
  - count is $clog2(DEPTH)+1 bits.
  - Per-entry valid bits are asserted on push and cleared on pop.
- Reset (asynchronous, rst_l low):
  - Pointers, count, valid bits and starve counter go to 0.
  - stbuf_empty=1; stbuf_full=0; dccm_wren=0; ld_stall=0; fwd_hit=0.
  - Any store in flight is discarded.
- Drain (combinational from the head entry):
  - drain = ~stbuf_empty & ~lsu_freeze_dc3 & (~ld_rden | force).
  - dccm_wren=drain; dccm_wr_addr and dccm_wr_data come from the head entry.
  - dccm_wr_addr and dccm_wr_data are don't-care when dccm_wren=0, but are driven to 0 when empty.
  - Pop occurs at the clock edge when drain=1.
- Push:
  - Accepted when stbuf_push & (~stbuf_full | drain). This includes push-while-full with a same-cycle pop.
  - A push while full with no pop is dropped. The simulation assertion lsu_wrbuf_overflow fires.
  - The new entry is visible on outputs the next cycle.
  - Push into an empty buffer is never drained in the same cycle (no bypass); first possible write is one cycle later.
- Count update: +1 push only, -1 pop only, unchanged on both or neither.
- Starvation:
  - starve_cnt increments each cycle with stbuf_full & ld_rden & ~lsu_freeze_dc3, and clears otherwise.
  - force = (starve_cnt == STARVE_MAX-1) & stbuf_full.
  - ld_stall=force & ld_rden, so the load pipe must not read this cycle. The counter clears on the forced pop.
  - While frozen, the counter holds its value.
- Forwarding (combinational, zero latency):
  - Compares fwd_addr[ADDR_W-1:2] against all valid entries.
  - Selects the youngest match, with age measured from rd_ptr. The entry being popped this cycle still participates.
  - A same-cycle push does not participate.
  - fwd_data=0 when fwd_hit=0.
- Freeze: draining stops; push and forwarding continue normally.

Decomposition:
- Shared package swerv_types gets the following, so the load pipe uses the same encoding:
  - wrbuf_entry_t (addr, data) typedef.
  - WRBUF_DEPTH and WRBUF_STARVE_MAX constants.
- One sub-module, lsu_wrbuf_fwd_match. It takes the valid vector, address array, rd_ptr and lookup address, and returns the one-hot youngest match plus hit. It is a pure combinational priority rotator.

Test Plan:
- Reset, push addr 0x0010/data 0x12345678, ld_rden=0 → next cycle dccm_wren=1, dccm_wr_addr=0x0010, dccm_wr_data=0x12345678; following cycle stbuf_empty=1.
- Push 4 stores with ld_rden=1 held → stbuf_full=1, count=4, dccm_wren=0; 8th full-blocked cycle ld_stall=1, dccm_wren=1 with the first entry's address; count drops to 3.
- Push 0x0020/0xA then 0x0022/0xB (same word), ld_rden=1, fwd_addr=0x0020 → fwd_hit=1, fwd_data=0xB; fwd_addr=0x0040 → fwd_hit=0, fwd_data=0.
- Full buffer, ld_rden=0, push 0x0100 in the same cycle → push accepted, count stays 4, dccm_wr_addr is the oldest entry; after 4 drains the last write is to 0x0100.
- Two entries queued, lsu_freeze_dc3=1 for 3 cycles → dccm_wren=0 and count=2 throughout; freeze drops → two consecutive writes in FIFO order.
- Three entries queued, rst_l pulled low mid-drain → stbuf_empty=1 and dccm_wren=0 immediately, without waiting for clk; after release no writes occur.

Source files
------------

// File: rtl/swerv_types.sv
// Shared LSU type and constant definitions; the load pipe and the DCCM write
// buffer use the same entry layout and depth/starvation constants.
`ifndef RV_DCCM_BITS
`define RV_DCCM_BITS 16
`endif

package swerv_types;

    localparam int unsigned DCCM_BITS        = `RV_DCCM_BITS;
    localparam int unsigned DCCM_FDATA_WIDTH = 39;

    localparam int unsigned WRBUF_DEPTH      = 4;
    localparam int unsigned WRBUF_STARVE_MAX = 8;

    typedef struct packed {
        logic [DCCM_BITS-1:0]        addr;
        logic [DCCM_FDATA_WIDTH-1:0] data;
    } wrbuf_entry_t;

endpackage

// File: rtl/lsu_wrbuf_fwd_match.sv
// Youngest-match selector for store-to-load forwarding: scans entries oldest
// to youngest starting at rd_ptr and keeps the last valid word-address match.
module lsu_wrbuf_fwd_match #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 14
) (
    input  logic [DEPTH-1:0]          valid,
    input  logic [DEPTH-1:0][AW-1:0]  word_addr,
    input  logic [$clog2(DEPTH)-1:0]  rd_ptr,
    input  logic [AW-1:0]             lookup_addr,
    output logic [DEPTH-1:0]          match_sel,
    output logic                      hit
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    always_comb begin
        match_sel = '0;
        hit       = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (valid[idx] && (word_addr[idx] == lookup_addr)) begin
                match_sel      = '0;
                match_sel[idx] = 1'b1;
                hit            = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsu_dccm_wrbuf.sv
// Committed-store write buffer in front of the DCCM write port: FIFO drain
// when the load pipe leaves the array idle, starvation override, forwarding.
module lsu_dccm_wrbuf
    import swerv_types::*;
#(
    parameter int unsigned DEPTH      = WRBUF_DEPTH,
    parameter int unsigned ADDR_W     = DCCM_BITS,
    parameter int unsigned DATA_W     = DCCM_FDATA_WIDTH,
    parameter int unsigned STARVE_MAX = WRBUF_STARVE_MAX
) (
    input  logic                     clk,
    input  logic                     rst_l,
    input  logic                     lsu_freeze_dc3,
    input  logic                     stbuf_push,
    input  logic [ADDR_W-1:0]        stbuf_addr,
    input  logic [DATA_W-1:0]        stbuf_data,
    output logic                     stbuf_full,
    output logic                     stbuf_empty,
    output logic [$clog2(DEPTH):0]   stbuf_count,
    input  logic                     ld_rden,
    output logic                     ld_stall,
    input  logic [ADDR_W-1:0]        fwd_addr,
    output logic                     fwd_hit,
    output logic [DATA_W-1:0]        fwd_data,
    output logic                     dccm_wren,
    output logic [ADDR_W-1:0]        dccm_wr_addr,
    output logic [DATA_W-1:0]        dccm_wr_data
);

    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = PW + 1;
    localparam int unsigned SW  = $clog2(STARVE_MAX + 1);
    localparam int unsigned WAW = ADDR_W - 2;

    logic [ADDR_W-1:0]           addr_q [DEPTH];
    logic [DATA_W-1:0]           data_q [DEPTH];
    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0]            valid_nxt;
    logic [PW-1:0]               rd_ptr;
    logic [PW-1:0]               wr_ptr;
    logic [CW-1:0]               count;
    logic [SW-1:0]               starve_cnt;
    logic                        drain;
    logic                        push_ok;
    logic                        force_drain;
    logic [DEPTH-1:0][WAW-1:0]   word_addr;
    logic [DEPTH-1:0]            fwd_sel;
    logic                        unused_fwd_lsb;

    assign stbuf_empty  = (count == '0);
    assign stbuf_full   = (count == CW'(DEPTH));
    assign stbuf_count  = count;
    assign force_drain  = (starve_cnt == SW'(STARVE_MAX - 1)) & stbuf_full;
    assign drain        = ~stbuf_empty & ~lsu_freeze_dc3 & (~ld_rden | force_drain);
    assign push_ok      = stbuf_push & (~stbuf_full | drain);
    assign ld_stall     = force_drain & ld_rden;
    assign dccm_wren    = drain;
    assign dccm_wr_addr = stbuf_empty ? '0 : addr_q[rd_ptr];
    assign dccm_wr_data = stbuf_empty ? '0 : data_q[rd_ptr];

    // Clear before set: a push-while-full with pop reuses the popped slot.
    always_comb begin
        valid_nxt = valid_q;
        if (drain)   valid_nxt[rd_ptr] = 1'b0;
        if (push_ok) valid_nxt[wr_ptr] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            valid_q    <= '0;
            starve_cnt <= '0;
        end else begin
            if (drain)   rd_ptr <= rd_ptr + PW'(1);
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            case ({push_ok, drain})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            valid_q <= valid_nxt;
            if (lsu_freeze_dc3)
                starve_cnt <= starve_cnt;
            else if (stbuf_full & ld_rden & ~force_drain)
                starve_cnt <= starve_cnt + SW'(1);
            else
                starve_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_q[wr_ptr] <= stbuf_addr;
            data_q[wr_ptr] <= stbuf_data;
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < DEPTH; k++)
            word_addr[k] = addr_q[k][ADDR_W-1:2];
    end

    lsu_wrbuf_fwd_match #(
        .DEPTH (DEPTH),
        .AW    (WAW)
    ) u_fwd_match (
        .valid       (valid_q),
        .word_addr   (word_addr),
        .rd_ptr      (rd_ptr),
        .lookup_addr (fwd_addr[ADDR_W-1:2]),
        .match_sel   (fwd_sel),
        .hit         (fwd_hit)
    );

    assign unused_fwd_lsb = ^fwd_addr[1:0];

    always_comb begin
        fwd_data = '0;
        for (int unsigned k = 0; k < DEPTH; k++)
            if (fwd_sel[k]) fwd_data = fwd_data | data_q[k];
    end

    lsu_wrbuf_overflow: assert property (@(posedge clk) disable iff (!rst_l)
        !(stbuf_push && stbuf_full && !drain));

endmodule
